// File: rtl/model_matrix_float_adder_sequencer_pkg.sv
// Shared definitions for the matrix float add/subtract sequencer.
// Holds the FSM state encoding, the data/control constants and the operation encoding.
package model_matrix_float_adder_sequencer_pkg;

    localparam int DATA_W    = 64;
    localparam int CONTROL_W = 4;

    typedef enum logic [1:0] {
        STARTER_STATE   = 2'd0,
        ROW_START_STATE = 2'd1,
        STREAM_STATE    = 2'd2,
        ENDER_STATE     = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0]    ZERO_DATA    = '0;
    localparam logic [DATA_W-1:0]    ONE_DATA     = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CONTROL_W-1:0] ZERO_CONTROL = '0;
    localparam logic [CONTROL_W-1:0] ONE_CONTROL  = {{(CONTROL_W-1){1'b0}}, 1'b1};

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/model_matrix_float_adder_sequencer.sv
// Row loop for a matrix float add/subtract on one shared external vector float adder.
// Issues one vector START per row, forwards element strobes and re-tags the results.
//
// state     | meaning
// STARTER   | idle, waiting for START; latches sizes and operation
// ROW_START | one-cycle vector adder start for the current row
// STREAM    | forwarding A/B elements, waiting for the row to finish
// ENDER     | matrix done, READY pulse follows
module model_matrix_float_adder_sequencer
    import model_matrix_float_adder_sequencer_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 OPERATION,
    input  logic                 DATA_A_IN_I_ENABLE,
    input  logic                 DATA_A_IN_J_ENABLE,
    input  logic                 DATA_B_IN_I_ENABLE,
    input  logic                 DATA_B_IN_J_ENABLE,
    output logic                 DATA_OUT_I_ENABLE,
    output logic                 DATA_OUT_J_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 VA_START,
    input  logic                 VA_READY,
    output logic                 VA_OPERATION,
    output logic                 VA_DATA_A_IN_ENABLE,
    output logic                 VA_DATA_B_IN_ENABLE,
    input  logic                 VA_DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] VA_SIZE_IN,
    output logic [DATA_SIZE-1:0] VA_DATA_A_IN,
    output logic [DATA_SIZE-1:0] VA_DATA_B_IN,
    input  logic [DATA_SIZE-1:0] VA_DATA_OUT
);

    localparam int UNUSED_CONTROL_SIZE = CONTROL_SIZE;

    // Row-start markers on the inputs carry no information the row loop needs.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, DATA_A_IN_I_ENABLE, DATA_B_IN_I_ENABLE};

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   size_i_q, size_i_d, size_j_q, size_j_d;
    logic [DATA_SIZE-1:0]   row_q, row_d;
    logic                   op_q, op_d, first_q, first_d;
    logic                   ready_q, ready_d, va_start_q, va_start_d;
    logic                   out_i_q, out_i_d, out_j_q, out_j_d;
    logic                   va_a_en_q, va_a_en_d, va_b_en_q, va_b_en_d;
    logic [DATA_SIZE-1:0]   data_out_q, data_out_d;
    logic [DATA_SIZE-1:0]   va_a_q, va_a_d, va_b_q, va_b_d;

    always_comb begin
        state_d    = state_q;
        size_i_d   = size_i_q;
        size_j_d   = size_j_q;
        row_d      = row_q;
        op_d       = op_q;
        first_d    = first_q;
        ready_d    = 1'b0;
        va_start_d = 1'b0;
        out_i_d    = 1'b0;
        out_j_d    = 1'b0;
        va_a_en_d  = 1'b0;
        va_b_en_d  = 1'b0;
        data_out_d = data_out_q;
        va_a_d     = va_a_q;
        va_b_d     = va_b_q;

        // Results are collected in every state so a row-ending result is never lost.
        if (VA_DATA_OUT_ENABLE) begin
            data_out_d = VA_DATA_OUT;
            out_j_d    = 1'b1;
            out_i_d    = first_q;
            first_d    = 1'b0;
        end

        case (state_q)
            STARTER_STATE: begin
                if (START) begin
                    size_i_d = SIZE_I_IN;
                    size_j_d = SIZE_J_IN;
                    op_d     = OPERATION;
                    row_d    = DATA_SIZE'(ZERO_DATA);
                    if ((SIZE_I_IN == '0) || (SIZE_J_IN == '0)) begin
                        state_d = ENDER_STATE;
                    end else begin
                        state_d = ROW_START_STATE;
                    end
                end
            end
            ROW_START_STATE: begin
                va_start_d = 1'b1;
                first_d    = 1'b1;
                state_d    = STREAM_STATE;
            end
            STREAM_STATE: begin
                va_a_en_d = DATA_A_IN_J_ENABLE;
                va_a_d    = DATA_A_IN;
                va_b_en_d = DATA_B_IN_J_ENABLE;
                va_b_d    = DATA_B_IN;
                if (VA_READY) begin
                    if (row_q == size_i_q - DATA_SIZE'(ONE_DATA)) begin
                        state_d = ENDER_STATE;
                    end else begin
                        row_d   = row_q + DATA_SIZE'(ONE_DATA);
                        state_d = ROW_START_STATE;
                    end
                end
            end
            ENDER_STATE: begin
                ready_d = 1'b1;
                state_d = STARTER_STATE;
            end
            default: state_d = STARTER_STATE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= STARTER_STATE;
            size_i_q   <= '0;
            size_j_q   <= '0;
            row_q      <= '0;
            op_q       <= OP_ADD;
            first_q    <= 1'b0;
            ready_q    <= 1'b0;
            va_start_q <= 1'b0;
            out_i_q    <= 1'b0;
            out_j_q    <= 1'b0;
            va_a_en_q  <= 1'b0;
            va_b_en_q  <= 1'b0;
            data_out_q <= '0;
            va_a_q     <= '0;
            va_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            size_i_q   <= size_i_d;
            size_j_q   <= size_j_d;
            row_q      <= row_d;
            op_q       <= op_d;
            first_q    <= first_d;
            ready_q    <= ready_d;
            va_start_q <= va_start_d;
            out_i_q    <= out_i_d;
            out_j_q    <= out_j_d;
            va_a_en_q  <= va_a_en_d;
            va_b_en_q  <= va_b_en_d;
            data_out_q <= data_out_d;
            va_a_q     <= va_a_d;
            va_b_q     <= va_b_d;
        end
    end

    assign READY               = ready_q;
    assign DATA_OUT            = data_out_q;
    assign DATA_OUT_I_ENABLE   = out_i_q;
    assign DATA_OUT_J_ENABLE   = out_j_q;
    assign VA_START            = va_start_q;
    assign VA_OPERATION        = op_q;
    assign VA_SIZE_IN          = size_j_q;
    assign VA_DATA_A_IN_ENABLE = va_a_en_q;
    assign VA_DATA_B_IN_ENABLE = va_b_en_q;
    assign VA_DATA_A_IN        = va_a_q;
    assign VA_DATA_B_IN        = va_b_q;

endmodule

// File: tb/tb_model_matrix_float_adder_sequencer.sv
// Bench for the matrix float adder sequencer with a behavioural vector adder
// behind the VA_* ports and a per-element expected-result queue.
module tb_model_matrix_float_adder_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START, READY, OPERATION;
    logic        DATA_A_IN_I_ENABLE, DATA_A_IN_J_ENABLE;
    logic        DATA_B_IN_I_ENABLE, DATA_B_IN_J_ENABLE;
    logic        DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE;
    logic [63:0] SIZE_I_IN, SIZE_J_IN, DATA_A_IN, DATA_B_IN, DATA_OUT;
    logic        VA_START, VA_READY, VA_OPERATION;
    logic        VA_DATA_A_IN_ENABLE, VA_DATA_B_IN_ENABLE, VA_DATA_OUT_ENABLE;
    logic [63:0] VA_SIZE_IN, VA_DATA_A_IN, VA_DATA_B_IN, VA_DATA_OUT;

    model_matrix_float_adder_sequencer #(.DATA_SIZE(64), .CONTROL_SIZE(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .OPERATION(OPERATION),
        .DATA_A_IN_I_ENABLE(DATA_A_IN_I_ENABLE), .DATA_A_IN_J_ENABLE(DATA_A_IN_J_ENABLE),
        .DATA_B_IN_I_ENABLE(DATA_B_IN_I_ENABLE), .DATA_B_IN_J_ENABLE(DATA_B_IN_J_ENABLE),
        .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
        .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN), .DATA_A_IN(DATA_A_IN),
        .DATA_B_IN(DATA_B_IN), .DATA_OUT(DATA_OUT), .VA_START(VA_START),
        .VA_READY(VA_READY), .VA_OPERATION(VA_OPERATION),
        .VA_DATA_A_IN_ENABLE(VA_DATA_A_IN_ENABLE), .VA_DATA_B_IN_ENABLE(VA_DATA_B_IN_ENABLE),
        .VA_DATA_OUT_ENABLE(VA_DATA_OUT_ENABLE), .VA_SIZE_IN(VA_SIZE_IN),
        .VA_DATA_A_IN(VA_DATA_A_IN), .VA_DATA_B_IN(VA_DATA_B_IN), .VA_DATA_OUT(VA_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural vector adder: pairs A/B elements, returns a +/- b, then row done.
    logic        coinc = 1'b0;
    logic [63:0] qa[$], qb[$];
    logic [63:0] m_len, m_emit;
    logic        m_op, m_active = 1'b0, m_pend = 1'b0;
    real         ra, rb;
    always @(negedge CLK) begin
        VA_DATA_OUT_ENABLE = 1'b0;
        VA_READY           = 1'b0;
        if (!RST) begin
            qa.delete(); qb.delete();
            m_active = 1'b0; m_pend = 1'b0;
        end else begin
            if (m_pend) begin
                VA_READY = 1'b1; m_pend = 1'b0; m_active = 1'b0;
            end
            if (VA_START) begin
                m_len = VA_SIZE_IN; m_op = VA_OPERATION; m_emit = 0; m_active = 1'b1;
                qa.delete(); qb.delete();
            end
            if (VA_DATA_A_IN_ENABLE) qa.push_back(VA_DATA_A_IN);
            if (VA_DATA_B_IN_ENABLE) qb.push_back(VA_DATA_B_IN);
            if (m_active && qa.size() > 0 && qb.size() > 0 && m_emit < m_len) begin
                ra = $bitstoreal(qa.pop_front());
                rb = $bitstoreal(qb.pop_front());
                VA_DATA_OUT = $realtobits(m_op ? ra - rb : ra + rb);
                VA_DATA_OUT_ENABLE = 1'b1;
                m_emit++;
                if (m_emit == m_len) begin
                    if (coinc) begin
                        VA_READY = 1'b1; m_active = 1'b0;
                    end else begin
                        m_pend = 1'b1;
                    end
                end
            end
        end
    end

    // Output monitor
    int          n_va = 0, n_ready = 0, ready_cyc = 0, outs_at_ready = 0;
    logic [63:0] va_size_q[$];
    logic        va_op_q[$];
    logic [63:0] out_q[$];
    logic        out_i_q[$];
    always @(negedge CLK) begin
        if (RST) begin
            if (VA_START) begin
                n_va++; va_size_q.push_back(VA_SIZE_IN); va_op_q.push_back(VA_OPERATION);
            end
            if (DATA_OUT_J_ENABLE) begin
                out_q.push_back(DATA_OUT); out_i_q.push_back(DATA_OUT_I_ENABLE);
            end
            if (READY) begin
                n_ready++; ready_cyc = cyc; outs_at_ready = out_q.size();
            end
        end
    end

    logic [63:0] exp_q[$];
    int          start_cyc;

    task automatic idle_inputs();
        START = 0;
        DATA_A_IN_I_ENABLE = 0; DATA_A_IN_J_ENABLE = 0;
        DATA_B_IN_I_ENABLE = 0; DATA_B_IN_J_ENABLE = 0;
    endtask

    task automatic wait_va_start(output bit got);
        got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (VA_START) begin got = 1; break; end
        end
    endtask

    task automatic drive_elem(input int c, input bit op, input bit fixed, input real fa, input real fb);
        real a, b;
        a = fixed ? fa : real'($urandom_range(0, 400)) / 4.0;
        b = fixed ? fb : real'($urandom_range(0, 400)) / 4.0;
        DATA_A_IN = $realtobits(a); DATA_B_IN = $realtobits(b);
        DATA_A_IN_J_ENABLE = 1; DATA_B_IN_J_ENABLE = 1;
        DATA_A_IN_I_ENABLE = (c == 0); DATA_B_IN_I_ENABLE = (c == 0);
        exp_q.push_back($realtobits(op ? a - b : a + b));
    endtask

    task automatic run(input int si, input int sj, input bit op, input bit restart,
                       input bit fixed, input real fa, input real fb,
                       input int exp_va, input int exp_outs);
        int  b_va, b_ready, b_out, nout;
        bit  got;
        b_va = n_va; b_ready = n_ready; b_out = out_q.size();
        exp_q.delete();
        @(negedge CLK);
        SIZE_I_IN = 64'(si); SIZE_J_IN = 64'(sj); OPERATION = op; START = 1;
        start_cyc = cyc;
        @(negedge CLK);
        START = 0;
        if (si > 0 && sj > 0) begin
            for (int r = 0; r < si; r++) begin
                wait_va_start(got);
                chk($sformatf("va_start_seen_row%0d", r), 64'(got), 64'd1);
                if (!got) break;
                for (int c = 0; c < sj; c++) begin
                    if (c > 0) @(negedge CLK);
                    drive_elem(c, op, fixed, fa, fb);
                    START = (restart && r == 0 && c == 0);
                end
                @(negedge CLK);
                idle_inputs();
            end
        end
        for (int k = 0; k < 200; k++) begin
            if (n_ready > b_ready) break;
            @(negedge CLK);
        end
        repeat (6) @(negedge CLK);
        chk("va_start_count", 64'(n_va - b_va), 64'(exp_va));
        for (int k = b_va; k < n_va; k++) begin
            chk("va_size_in", va_size_q[k], 64'(sj));
            chk("va_operation", 64'(va_op_q[k]), 64'(op));
        end
        nout = out_q.size() - b_out;
        chk("output_count", 64'(nout), 64'(exp_outs));
        for (int k = 0; k < nout && k < exp_q.size(); k++) begin
            chk($sformatf("data_out[%0d]", k), out_q[b_out + k], exp_q[k]);
            chk($sformatf("data_out_i_enable[%0d]", k), 64'(out_i_q[b_out + k]), 64'((k % sj) == 0));
        end
        chk("ready_count", 64'(n_ready - b_ready), 64'd1);
        chk("outputs_before_ready", 64'(outs_at_ready - b_out), 64'(exp_outs));
        if (si == 0 || sj == 0)
            chk("ready_latency_zero_size", 64'(ready_cyc - start_cyc), 64'd2);
    endtask

    function automatic logic any_output_set();
        return |{READY, DATA_OUT, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, VA_START, VA_OPERATION,
                 VA_DATA_A_IN_ENABLE, VA_DATA_B_IN_ENABLE, VA_SIZE_IN, VA_DATA_A_IN, VA_DATA_B_IN};
    endfunction

    typedef struct {
        int  si; int sj; bit op; bit coinc; bit restart; bit fixed;
        real a; real b; int exp_va; int exp_outs;
    } vec_t;
    vec_t tbl[6];

    initial begin
        bit got;
        int si, sj;
        tbl[0] = '{2, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1.0, 2.0, 2, 6};
        tbl[1] = '{1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 5.0, 2.0, 1, 1};
        tbl[2] = '{0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0.0, 0.0, 0, 0};
        tbl[3] = '{2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0.0, 0.0, 2, 4};
        tbl[4] = '{2, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0.0, 0.0, 2, 6};
        tbl[5] = '{3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0.0, 0.0, 0, 0};

        RST = 0; OPERATION = 0; SIZE_I_IN = 0; SIZE_J_IN = 0;
        DATA_A_IN = 0; DATA_B_IN = 0; VA_DATA_OUT = 0;
        VA_READY = 0; VA_DATA_OUT_ENABLE = 0;
        idle_inputs();
        repeat (3) @(posedge CLK);
        #1 chk("reset_outputs_zero", 64'(any_output_set()), 64'd0);
        @(negedge CLK) RST = 1;

        chk("fixed_sum_is_3p0", $realtobits(1.0 + 2.0), 64'h4008000000000000);

        for (int t = 0; t < 6; t++) begin
            coinc = tbl[t].coinc;
            run(tbl[t].si, tbl[t].sj, tbl[t].op, tbl[t].restart, tbl[t].fixed,
                tbl[t].a, tbl[t].b, tbl[t].exp_va, tbl[t].exp_outs);
        end
        coinc = 0;

        // Asynchronous reset in the middle of row 1 of a 3x2
        @(negedge CLK);
        SIZE_I_IN = 3; SIZE_J_IN = 2; OPERATION = 0; START = 1;
        @(negedge CLK);
        START = 0;
        wait_va_start(got);
        chk("rst_test_row0_start", 64'(got), 64'd1);
        drive_elem(0, 0, 1, 1.0, 1.0);
        @(negedge CLK) drive_elem(1, 0, 1, 1.0, 1.0);
        @(negedge CLK) idle_inputs();
        wait_va_start(got);
        chk("rst_test_row1_start", 64'(got), 64'd1);
        drive_elem(0, 0, 1, 1.0, 1.0);
        #2 RST = 0;
        #1 chk("reset_mid_row_outputs_zero", 64'(any_output_set()), 64'd0);
        idle_inputs();
        @(negedge CLK);
        @(negedge CLK) RST = 1;
        run(1, 2, 1'b0, 1'b0, 1'b0, 0.0, 0.0, 1, 2);

        for (int t = 0; t < 6; t++) begin
            si = $urandom_range(1, 3);
            sj = $urandom_range(1, 4);
            coinc = 1'($urandom_range(0, 1));
            run(si, sj, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0.0, 0.0, si, si * sj);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
